// File: rtl/y_run_logger.sv
// y_run_logger
//   Measures the length of every high run of the registered detector output
//   y_in and queues each length in a small first-word-fall-through FIFO.
//   The queued records are read out over a valid/ready handshake.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   y_in        detector output (already registered upstream)
//   en          logging enable; dropping it mid-run discards the run
//   rd_ready    consumer accepts the head record
//   rd_valid    head record available
//   rd_len      head record run length (capped at 2^CNT_W-1), 0 when empty
//   rd_sat      head record length exceeded the cap, 0 when empty
//   fifo_level  number of queued records
//   drop_cnt    records lost to a full FIFO, saturates at 255
//   busy        a run is currently being measured
module y_run_logger #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         y_in,
    input  logic                         en,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [CNT_W-1:0]             rd_len,
    output logic                         rd_sat,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [7:0]                   drop_cnt,
    output logic                         busy
);

    localparam int unsigned   AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned   LW      = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               sat, sat_nxt;
    logic               y_d;
    logic               rise;
    logic               push;
    logic               pop;
    logic               push_ok;

    logic [CNT_W:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CNT_W:0]     head;

    // y_d resets high so a run already in progress at reset release
    // never produces a rising edge and is therefore never logged.
    assign rise = y_in & ~y_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sat   <= 1'b0;
            y_d   <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sat   <= sat_nxt;
            y_d   <= y_in;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sat_nxt   = sat;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (en && rise) begin
                    cnt_nxt   = CNT_W'(1);
                    sat_nxt   = 1'b0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (y_in) begin
                    if (cnt != '1) begin
                        cnt_nxt = cnt + 1'b1;
                    end else begin
                        sat_nxt = 1'b1;
                    end
                end else begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // FIFO: a push into a full FIFO still succeeds when the head is popped
    // on the same edge; the write then lands in the slot being vacated.
    assign rd_valid = (fifo_level != '0);
    assign pop      = rd_valid & rd_ready;
    assign push_ok  = push & ((fifo_level < DEPTH_L) | pop);
    assign head     = mem[rd_ptr];
    assign rd_len   = rd_valid ? head[CNT_W-1:0] : '0;
    assign rd_sat   = rd_valid & head[CNT_W];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {sat, cnt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_cnt   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (push && !push_ok && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_y_run_logger.sv
// tb_y_run_logger
//   Directed-vector bench for y_run_logger (CNT_W=4, FIFO_DEPTH=4).
//   Stimulus pushes each expected record {sat,len} into a queue; a monitor
//   pops and compares every time the DUT hands a record to the consumer.
module tb_y_run_logger;

    localparam int unsigned CW = 4;
    localparam int unsigned D  = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   y_in;
    logic                   en;
    logic                   rd_ready;
    logic                   rd_valid;
    logic [CW-1:0]          rd_len;
    logic                   rd_sat;
    logic [$clog2(D):0]     fifo_level;
    logic [7:0]             drop_cnt;
    logic                   busy;

    int n_cmp;
    int n_bad;
    logic [CW:0] sb [$];

    y_run_logger #(
        .CNT_W      (CW),
        .FIFO_DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .y_in       (y_in),
        .en         (en),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_len     (rd_len),
        .rd_sat     (rd_sat),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // drive y_in for one cycle; returns 1 time unit after the sampling edge
    task automatic step(input logic y);
        y_in = y;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input logic y, input int n);
        for (int i = 0; i < n; i++) step(y);
    endtask

    task automatic exp_rec(input int len, input logic s);
        logic [CW:0] r;
        r = {s, CW'(len)};
        sb.push_back(r);
    endtask

    // scoreboard monitor: a record is consumed on the next edge
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_record actual len=%0d sat=%0d required none", rd_len, rd_sat);
            end else begin
                logic [CW:0] e;
                e = sb.pop_front();
                if ({rd_sat, rd_len} !== e) begin
                    n_bad++;
                    $display("FAIL record actual len=%0d sat=%0d required len=%0d sat=%0d",
                             rd_len, rd_sat, e[CW-1:0], e[CW]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        y_in     = 1'b1;
        en       = 1'b1;
        rd_ready = 1'b1;

        // reset state, with y_in already high
        #12;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_len", rd_len, 0);
        chk("rst_rd_sat", rd_sat, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // run already high at reset release is never logged
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            chk("hi_at_reset_busy", busy, 0);
        end
        steps(1'b0, 2);
        chk("hi_at_reset_no_rec", rd_valid, 0);

        // basic run of 5
        steps(1'b0, 3);
        exp_rec(5, 1'b0);
        steps(1'b1, 5);
        chk("basic_busy", busy, 1);
        chk("basic_valid_pre", rd_valid, 0);
        step(1'b0);
        chk("basic_valid_rise", rd_valid, 1);
        chk("basic_len", rd_len, 5);
        step(1'b0);
        chk("basic_valid_fall", rd_valid, 0);
        chk("basic_busy_end", busy, 0);

        // saturation: 20 cycles -> 15/sat, exactly 15 -> 15/no sat
        exp_rec(15, 1'b1);
        steps(1'b1, 20);
        steps(1'b0, 2);
        exp_rec(15, 1'b0);
        steps(1'b1, 15);
        steps(1'b0, 3);

        // enable abort; re-enable while high must not restart
        steps(1'b1, 3);
        en = 1'b0;
        step(1'b1);
        chk("abort_busy", busy, 0);
        en = 1'b1;
        steps(1'b1, 2);
        chk("abort_no_restart", busy, 0);
        steps(1'b0, 2);
        chk("abort_no_rec", fifo_level, 0);
        exp_rec(2, 1'b0);
        steps(1'b1, 2);
        steps(1'b0, 3);

        // full FIFO: 2,3,4,5 kept, 6 dropped
        rd_ready = 1'b0;
        for (int l = 2; l <= 6; l++) begin
            if (l < 6) exp_rec(l, 1'b0);
            steps(1'b1, l);
            steps(1'b0, 2);
        end
        chk("full_level", fifo_level, 4);
        chk("full_drop", drop_cnt, 1);
        chk("full_head", rd_len, 2);
        rd_ready = 1'b1;
        steps(1'b0, 5);
        chk("drain_valid", rd_valid, 0);
        chk("drain_level", fifo_level, 0);

        // simultaneous push/pop on a full FIFO; back-to-back short runs
        rd_ready = 1'b0;
        for (int l = 1; l <= 4; l++) begin
            exp_rec(l, 1'b0);
            steps(1'b1, l);
            step(1'b0);
        end
        chk("sim_full_level", fifo_level, 4);
        step(1'b0);
        exp_rec(7, 1'b0);
        steps(1'b1, 7);
        rd_ready = 1'b1;
        step(1'b0);
        rd_ready = 1'b0;
        chk("sim_level", fifo_level, 4);
        chk("sim_drop", drop_cnt, 1);
        chk("sim_head", rd_len, 2);
        step(1'b0);
        chk("sim_level_hold", fifo_level, 4);
        rd_ready = 1'b1;
        steps(1'b0, 5);
        chk("sim_drain_level", fifo_level, 0);

        // async reset mid-run with two records queued
        rd_ready = 1'b0;
        steps(1'b1, 3);
        steps(1'b0, 2);
        steps(1'b1, 4);
        steps(1'b0, 2);
        chk("pre_rst_level", fifo_level, 2);
        chk("pre_rst_head", rd_len, 3);
        steps(1'b1, 2);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_rd_len", rd_len, 0);
        chk("arst_rd_sat", rd_sat, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_drop", drop_cnt, 0);
        chk("arst_busy", busy, 0);
        #1;
        rst_n = 1'b1;
        rd_ready = 1'b1;
        steps(1'b0, 2);
        chk("post_rst_level", fifo_level, 0);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/y_run_logger.md
Name: y_run_logger

Overview:
- Sits directly downstream of the 1-bit sequence-detector FSM and consumes its registered output Y.
- Measures the length, in clock cycles, of every high run of Y.
- Queues each measured length in a small first-word-fall-through FIFO.
- Presents queued lengths to a consumer over a valid/ready handshake. Lets firmware or a bench histogram detector activity without sampling Y every cycle.

Parameters:
- CNT_W, 8: width of the run-length counter and of rd_len.
- FIFO_DEPTH, 4: number of queued records. Must be a power of 2 and ≥2.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- y_in  in  1  detector output. Already registered upstream; no synchroniser is applied.
- en  in  1  logging enable.
- rd_ready  in  1  consumer accepts the head record.
- rd_valid  out  1  head record available.
- rd_len  out  CNT_W  run length of the head record.
- rd_sat  out  1  head record's length exceeded 2^CNT_W-1.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued records.
- drop_cnt  out  8  records lost to a full FIFO. Saturates at 255.
- busy  out  1  a run is currently being measured.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Clears the FSM to IDLE, and clears the counter and the FIFO pointers.
  - Outputs: rd_valid=0, rd_len=0, rd_sat=0, fifo_level=0, drop_cnt=0, busy=0.
  - The y_in history register y_d resets to 1. A run already high when reset releases is never logged.
  - Reset asserted mid-run discards the run.
- y_d <= y_in every cycle. A rising edge means y_in=1 and y_d=0.
- FSM has two states, IDLE and RUN:
  - IDLE: on en=1 and a rising edge, cnt <= 1, sat <= 0, go to RUN. Otherwise stay.
  - RUN, en=0: discard the run and go to IDLE; no record is written. Re-asserting en while y_in is still high does not restart the measurement; the FSM waits for the next rising edge.
  - RUN, en=1, y_in=1:
    - If cnt < 2^CNT_W-1, cnt <= cnt+1.
    - If cnt is already at 2^CNT_W-1, cnt holds and sat <= 1.
  - RUN, en=1, y_in=0: push record {cnt, sat} and go to IDLE.
- busy = (state == RUN), registered.
- Length rule: rd_len equals the number of cycles y_in was sampled high, capped at 2^CNT_W-1. rd_sat=1 only if the true length exceeded the cap.
- Latency: if the first cycle sampling y_in=0 after a run is cycle t, the record is written at the clock edge ending cycle t. rd_valid rises in cycle t+1 when the FIFO was empty.
- FIFO:
  - First-word-fall-through. rd_len/rd_sat show the head while rd_valid=1, and are 0 when the FIFO is empty.
  - A pop occurs on a clock edge with rd_valid=1 and rd_ready=1.
  - rd_valid is never withdrawn without a pop.
- Push rules:
  - A push succeeds if fifo_level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Full FIFO, no pop: the record is dropped and drop_cnt increments (saturating).
  - Simultaneous push and pop on a non-empty FIFO leaves fifo_level unchanged.
  - A pop on an empty FIFO is impossible (rd_valid=0).
- fifo_level is registered and updates on the same edge as the push/pop.
- Runs as short as 1 cycle are valid: a pattern of y_in 0,1,0 logs len=1.
- Back-to-back runs 1,0,1 log two separate records.

Test Plan:
- Basic run: en=1, rd_ready=1, y_in low 3 cycles, high 5 cycles, then low → one record len=5, rd_sat=0. rd_valid is high for exactly 1 cycle, starting the cycle after the first low sample.
- Saturation: CNT_W=4, y_in high 20 cycles → len=15, rd_sat=1. A separate run of exactly 15 cycles → len=15, rd_sat=0.
- Full FIFO:
  - Setup: rd_ready=0, runs of length 2,3,4,5,6 separated by 2 low cycles.
  - Expected while held: fifo_level=4, drop_cnt=1.
  - Then hold rd_ready=1 → records popped in order 2,3,4,5, then rd_valid=0 and fifo_level=0.
- Enable abort: en drops after 3 high cycles and returns while y_in is still high → no record. The next rising edge with 2 high cycles → len=2.
- Reset/edge cases:
  - y_in=1 when rst_n releases, held 6 cycles → no record and busy=0.
  - Async reset asserted mid-run with 2 records queued → all outputs 0 before the next clk edge.
- Simultaneous push/pop: FIFO full, rd_ready=1 on the cycle a run ends → no drop, drop_cnt unchanged, fifo_level stays 4, and the new record becomes the tail.
